bg_frame_ctl: RTL and testbench

- Frame-synchronous configuration controller for the background renderer in the VGA pixel pipeline.
- Game logic writes border and fill colours through a valid/ready port into shadow registers. The block commits them atomically to the active colour outputs at the next vertical-blank start, so a frame never shows a tear.
- Also provides a free-running frame counter and a commit strobe for downstream sequencing.

---
 rtl/bg_ctl_pkg.sv | 37 +++
 rtl/bg_flash_seq.sv | 39 +++
 rtl/bg_frame_ctl.sv | 126 ++++++++++++
 tb/tb_bg_frame_ctl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_ctl_pkg.sv
// Shared types and constants for the background frame controller.
// Address map, FSM encoding, colour type and default colours.
package bg_ctl_pkg;

  typedef logic [11:0] rgb_t;

  localparam logic [2:0] ADDR_FILL      = 3'd0;
  localparam logic [2:0] ADDR_TOP       = 3'd1;
  localparam logic [2:0] ADDR_BOT       = 3'd2;
  localparam logic [2:0] ADDR_LEFT      = 3'd3;
  localparam logic [2:0] ADDR_RIGHT     = 3'd4;
  localparam logic [2:0] ADDR_FLASH_RGB = 3'd5;
  localparam logic [2:0] ADDR_FLASH_PER = 3'd6;
  localparam logic [2:0] ADDR_COMMIT    = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam rgb_t DEF_FILL  = 12'hE8E;
  localparam rgb_t DEF_TOP   = 12'hFF0;
  localparam rgb_t DEF_BOT   = 12'hF00;
  localparam rgb_t DEF_LEFT  = 12'h0F0;
  localparam rgb_t DEF_RIGHT = 12'h00F;
  localparam rgb_t DEF_FLASH = 12'h000;

  typedef struct packed {
    rgb_t fill;
    rgb_t top;
    rgb_t bot;
    rgb_t left;
    rgb_t right;
  } colours_t;

endpackage

// File: rtl/bg_flash_seq.sv
// Fill-colour flash sequencer: counts vblank rises and toggles between the
// base fill and the flash colour every 'period' frames (period 0 = off).
module bg_flash_seq
  import bg_ctl_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  input  logic        vb_rise,
  input  logic        clear,
  input  logic [7:0]  period,
  input  logic [11:0] flash_rgb,
  input  logic [11:0] base_rgb,
  output logic [11:0] fill_rgb
);

  logic [7:0] sub_cnt;
  logic       flash_phase;

  // A commit restarts the flash cadence from the base colour.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sub_cnt     <= 8'd0;
      flash_phase <= 1'b0;
    end else if (clear) begin
      sub_cnt     <= 8'd0;
      flash_phase <= 1'b0;
    end else if (vb_rise && (period != 8'd0)) begin
      if (sub_cnt + 8'd1 == period) begin
        sub_cnt     <= 8'd0;
        flash_phase <= ~flash_phase;
      end else begin
        sub_cnt <= sub_cnt + 8'd1;
      end
    end
  end

  assign fill_rgb = flash_phase ? flash_rgb : base_rgb;

endmodule

// File: rtl/bg_frame_ctl.sv
// Frame-synchronous background colour controller: shadow writes are committed
// atomically at vblank start. Optional fill flashing via macro BG_FLASH_EN.
module bg_frame_ctl
  import bg_ctl_pkg::*;
#(
  parameter int          FRAME_W   = 16,
  parameter logic [11:0] FILL_DEF  = DEF_FILL,
  parameter logic [11:0] TOP_DEF   = DEF_TOP,
  parameter logic [11:0] BOT_DEF   = DEF_BOT,
  parameter logic [11:0] LEFT_DEF  = DEF_LEFT,
  parameter logic [11:0] RIGHT_DEF = DEF_RIGHT
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vblnk_in,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_addr,
  input  logic [11:0]        cfg_data,
  output logic [11:0]        fill_rgb,
  output logic [11:0]        top_rgb,
  output logic [11:0]        bot_rgb,
  output logic [11:0]        left_rgb,
  output logic [11:0]        right_rgb,
  output logic               commit_pulse,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam colours_t RST_COLOURS = '{FILL_DEF, TOP_DEF, BOT_DEF, LEFT_DEF, RIGHT_DEF};

  state_t   state, state_nxt;
  logic     vblnk_d;
  logic     vb_rise;
  logic     accept;
  colours_t shadow, active;

  assign vb_rise   = vblnk_in & ~vblnk_d;
  assign cfg_ready = (state != COMMIT);
  assign accept    = cfg_valid & cfg_ready;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      vblnk_d      <= 1'b0;
      frame_cnt    <= '0;
      commit_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      vblnk_d      <= vblnk_in;
      commit_pulse <= (state == COMMIT);
      if (vb_rise) frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

  // Commit requests in ARMED are absorbed; the commit itself lasts one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && (cfg_addr == ADDR_COMMIT)) state_nxt = ARMED;
      ARMED:   if (vb_rise) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      shadow <= RST_COLOURS;
    end else if (accept) begin
      case (cfg_addr)
        ADDR_FILL:  shadow.fill  <= cfg_data;
        ADDR_TOP:   shadow.top   <= cfg_data;
        ADDR_BOT:   shadow.bot   <= cfg_data;
        ADDR_LEFT:  shadow.left  <= cfg_data;
        ADDR_RIGHT: shadow.right <= cfg_data;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) active <= RST_COLOURS;
    else if (state == COMMIT) active <= shadow;
  end

  assign top_rgb   = active.top;
  assign bot_rgb   = active.bot;
  assign left_rgb  = active.left;
  assign right_rgb = active.right;

`ifdef BG_FLASH_EN
  rgb_t       flash_sh, flash_act;
  logic [7:0] period_sh, period_act;

  // Flash settings follow the same shadow/commit path as the colours.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      flash_sh   <= DEF_FLASH;
      flash_act  <= DEF_FLASH;
      period_sh  <= 8'd0;
      period_act <= 8'd0;
    end else begin
      if (accept && (cfg_addr == ADDR_FLASH_RGB)) flash_sh  <= cfg_data;
      if (accept && (cfg_addr == ADDR_FLASH_PER)) period_sh <= cfg_data[7:0];
      if (state == COMMIT) begin
        flash_act  <= flash_sh;
        period_act <= period_sh;
      end
    end
  end

  bg_flash_seq u_flash (
    .pclk      (pclk),
    .rst       (rst),
    .vb_rise   (vb_rise),
    .clear     (state == COMMIT),
    .period    (period_act),
    .flash_rgb (flash_act),
    .base_rgb  (active.fill),
    .fill_rgb  (fill_rgb)
  );
`else
  assign fill_rgb = active.fill;
`endif

endmodule

// File: tb/tb_bg_frame_ctl.sv
// Self-checking bench for bg_frame_ctl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_bg_frame_ctl;

  localparam int FW = 4;
  localparam logic [11:0] DEFS [0:4] = '{12'hE8E, 12'hFF0, 12'hF00, 12'h0F0, 12'h00F};

  logic          pclk = 1'b0;
  logic          rst;
  logic          vblnk_in;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_addr;
  logic [11:0]   cfg_data;
  logic [11:0]   fill_rgb, top_rgb, bot_rgb, left_rgb, right_rgb;
  logic          commit_pulse;
  logic [FW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  bg_frame_ctl #(.FRAME_W(FW)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .vblnk_in     (vblnk_in),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .fill_rgb     (fill_rgb),
    .top_rgb      (top_rgb),
    .bot_rgb      (bot_rgb),
    .left_rgb     (left_rgb),
    .right_rgb    (right_rgb),
    .commit_pulse (commit_pulse),
    .frame_cnt    (frame_cnt)
  );

  always #5 pclk = ~pclk;

  // Reference model: register files, a pending-commit flag and event rules.
  logic [11:0] m_sh [0:4];
  logic [11:0] m_act [0:4];
  logic [11:0] m_sh_fl, m_act_fl;
  int          m_sh_per, m_act_per, m_sub;
  bit          m_phase, m_armed, m_commit, m_pulse, m_vbprev;
  int          m_frame;

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      m_sh[i]  = DEFS[i];
      m_act[i] = DEFS[i];
    end
    m_sh_fl = 12'h000; m_act_fl = 12'h000;
    m_sh_per = 0; m_act_per = 0; m_sub = 0; m_phase = 1'b0;
    m_armed = 1'b0; m_commit = 1'b0; m_pulse = 1'b0; m_vbprev = 1'b0;
    m_frame = 0;
  endfunction

  function automatic void model_step(bit vb, bit valid, logic [2:0] addr, logic [11:0] data);
    bit rise = vb && !m_vbprev;
    bit acc  = valid && !m_commit;
    m_pulse = m_commit;
    if (m_commit) begin
      for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
      m_act_fl = m_sh_fl; m_act_per = m_sh_per; m_sub = 0; m_phase = 1'b0;
    end else if (rise && m_act_per != 0) begin
      m_sub++;
      if (m_sub == m_act_per) begin
        m_sub = 0;
        m_phase = !m_phase;
      end
    end
    if (acc && addr < 3'd5) m_sh[addr] = data;
    if (acc && addr == 3'd5) m_sh_fl = data;
    if (acc && addr == 3'd6) m_sh_per = int'(data[7:0]);
    m_commit = m_armed && rise;
    if (m_commit) m_armed = 1'b0;
    else if (acc && addr == 3'd7) m_armed = 1'b1;
    if (rise) m_frame = (m_frame + 1) % (1 << FW);
    m_vbprev = vb;
  endfunction

  function automatic int exp_fill();
`ifdef BG_FLASH_EN
    return m_phase ? int'(m_act_fl) : int'(m_act[0]);
`else
    return int'(m_act[0]);
`endif
  endfunction

  function automatic void cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic checkOutput();
    cmp("fill_rgb", int'(fill_rgb), exp_fill());
    cmp("top_rgb", int'(top_rgb), int'(m_act[1]));
    cmp("bot_rgb", int'(bot_rgb), int'(m_act[2]));
    cmp("left_rgb", int'(left_rgb), int'(m_act[3]));
    cmp("right_rgb", int'(right_rgb), int'(m_act[4]));
    cmp("commit_pulse", int'(commit_pulse), int'(m_pulse));
    cmp("frame_cnt", int'(frame_cnt), m_frame);
    cmp("cfg_ready", int'(cfg_ready), int'(!m_commit));
  endtask

  task automatic advance();
    @(posedge pclk);
    model_step(vblnk_in, cfg_valid, cfg_addr, cfg_data);
    #1;
  endtask

  task automatic drive(bit vb, bit valid, logic [2:0] addr, logic [11:0] data);
    vblnk_in = vb; cfg_valid = valid; cfg_addr = addr; cfg_data = data;
  endtask

  task automatic applyStimulus(bit vb, bit valid, logic [2:0] addr, logic [11:0] data);
    drive(vb, valid, addr, data);
    @(negedge pclk);
    checkOutput();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 12'h000);
    model_reset();
    #1;
    checkOutput();
    @(negedge pclk);
    rst = 1'b0;
    advance();
  endtask

  // One vblank pulse: rise cycle followed by two low cycles.
  task automatic frame();
    applyStimulus(1'b1, 1'b0, 3'd0, 12'h000);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000);
  endtask

  typedef struct {
    bit          vb;
    bit          valid;
    logic [2:0]  addr;
    logic [11:0] data;
    logic [11:0] fill;
    logic [11:0] top;
    logic [11:0] bot;
    bit          ready;
    bit          pulse;
    int          frame;
  } vec_t;

  vec_t tbl [8];

  initial begin
    // vb valid addr data | fill top bot ready pulse frame (values seen in that cycle)
    tbl[0] = '{1'b0, 1'b1, 3'd1, 12'h0F0, 12'hE8E, 12'hFF0, 12'hF00, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 3'd7, 12'h000, 12'hE8E, 12'hFF0, 12'hF00, 1'b1, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b1, 3'd0, 12'hABC, 12'hE8E, 12'hFF0, 12'hF00, 1'b1, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 3'd2, 12'h555, 12'hE8E, 12'hFF0, 12'hF00, 1'b0, 1'b0, 1};
    tbl[4] = '{1'b1, 1'b0, 3'd0, 12'h000, 12'hABC, 12'h0F0, 12'hF00, 1'b1, 1'b1, 1};
    tbl[5] = '{1'b0, 1'b0, 3'd0, 12'h000, 12'hABC, 12'h0F0, 12'hF00, 1'b1, 1'b0, 1};
    tbl[6] = '{1'b1, 1'b0, 3'd0, 12'h000, 12'hABC, 12'h0F0, 12'hF00, 1'b1, 1'b0, 1};
    tbl[7] = '{1'b0, 1'b0, 3'd0, 12'h000, 12'hABC, 12'h0F0, 12'hF00, 1'b1, 1'b0, 2};

    do_reset();

    $display("[TB] vector table: commit timing and same-cycle write");
    foreach (tbl[i]) begin
      drive(tbl[i].vb, tbl[i].valid, tbl[i].addr, tbl[i].data);
      @(negedge pclk);
      checkOutput();
      cmp("tbl_fill", int'(fill_rgb), int'(tbl[i].fill));
      cmp("tbl_top", int'(top_rgb), int'(tbl[i].top));
      cmp("tbl_bot", int'(bot_rgb), int'(tbl[i].bot));
      cmp("tbl_ready", int'(cfg_ready), int'(tbl[i].ready));
      cmp("tbl_pulse", int'(commit_pulse), int'(tbl[i].pulse));
      cmp("tbl_frame", int'(frame_cnt), tbl[i].frame);
      advance();
    end

    $display("[TB] idle frames after reset");
    do_reset();
    frame();
    frame();
    cmp("idle_frame_cnt", int'(frame_cnt), 2);
    cmp("idle_fill", int'(fill_rgb), 12'hE8E);
    cmp("idle_top", int'(top_rgb), 12'hFF0);

    $display("[TB] shadow write without commit");
    applyStimulus(1'b0, 1'b1, 3'd0, 12'h123);
    frame(); frame(); frame();
    cmp("nocommit_fill", int'(fill_rgb), 12'hE8E);

    $display("[TB] arming on a vblank rise waits a frame");
    applyStimulus(1'b0, 1'b1, 3'd4, 12'h321);
    applyStimulus(1'b1, 1'b1, 3'd7, 12'h000);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000);
    cmp("arm_only_right", int'(right_rgb), 12'h00F);
    frame();
    cmp("arm_later_right", int'(right_rgb), 12'h321);

    $display("[TB] reset during commit");
    do_reset();
    applyStimulus(1'b0, 1'b1, 3'd1, 12'h0F0);
    applyStimulus(1'b0, 1'b1, 3'd7, 12'h000);
    applyStimulus(1'b1, 1'b0, 3'd0, 12'h000);
    cmp("in_commit_ready", int'(cfg_ready), 0);
    do_reset();
    cmp("rst_top", int'(top_rgb), 12'hFF0);
    cmp("rst_pulse", int'(commit_pulse), 0);
    frame();
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000);
    cmp("post_rst_top", int'(top_rgb), 12'hFF0);

    $display("[TB] vblank held high");
    applyStimulus(1'b1, 1'b0, 3'd0, 12'h000);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 3'd0, 12'h000);
    cmp("held_frame_cnt", int'(frame_cnt), 2);
    applyStimulus(1'b0, 1'b0, 3'd0, 12'h000);

`ifdef BG_FLASH_EN
    $display("[TB] flash sequencing");
    do_reset();
    applyStimulus(1'b0, 1'b1, 3'd5, 12'h000);
    applyStimulus(1'b0, 1'b1, 3'd6, 12'h002);
    applyStimulus(1'b0, 1'b1, 3'd7, 12'h000);
    frame();
    cmp("flash_f0", int'(fill_rgb), 12'hE8E);
    frame(); frame();
    cmp("flash_f2", int'(fill_rgb), 12'h000);
    frame();
    cmp("flash_f3", int'(fill_rgb), 12'h000);
    frame();
    cmp("flash_f4", int'(fill_rgb), 12'hE8E);
    applyStimulus(1'b0, 1'b1, 3'd6, 12'h000);
    applyStimulus(1'b0, 1'b1, 3'd7, 12'h000);
    frame();
    for (int i = 0; i < 3; i++) begin
      frame();
      cmp("flash_off", int'(fill_rgb), 12'hE8E);
    end
`endif

    $display("[TB] randomized traffic");
    do_reset();
    begin
      bit vb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) vb = !vb;
        applyStimulus(vb, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      12'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
